// File: rtl/m1553_word_deser_pkg.sv
// Shared definitions for the 1553B receive word deserializer:
// FSM state encoding, word width and sync type constants.
package m1553_word_deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam int unsigned M1553_DW = 16;

  localparam logic SYNC_CMD = 1'b1;
  localparam logic SYNC_DAT = 1'b0;

endpackage

// File: rtl/m1553_bit_tmo.sv
// Inter-bit timeout counter for the 1553B word deserializer.
// Compiled only when M1553_WORD_TMO_EN is defined.
`ifdef M1553_WORD_TMO_EN
module m1553_bit_tmo #(
  parameter int unsigned TMO_CYC = 64,
  parameter int unsigned CW      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clr_i,
  output logic tmo_o
);

  localparam logic [CW-1:0] LIM = CW'(TMO_CYC);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count idle cycles while a word is in progress; saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIM) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmo_o = run_i & (cnt_q == LIM);

endmodule
`endif

// File: rtl/m1553_word_deser.sv
// 1553B word deserializer: sync + DW data bits (MSB first) + odd parity bit,
// presented on a one-deep valid/ready output with sticky overflow.
// Optional inter-bit timeout abort enabled by defining M1553_WORD_TMO_EN.
module m1553_word_deser
  import m1553_word_deser_pkg::*;
#(
  parameter int unsigned DW = M1553_DW
`ifdef M1553_WORD_TMO_EN
  ,
  parameter int unsigned TMO_CYC = 64,
  parameter int unsigned CW      = 7
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync_vld,
  input  logic          sync_cmd,
  input  logic          bit_vld,
  input  logic          bit_val,
  input  logic          bit_err,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_data,
  output logic          o_is_cmd,
  output logic          o_par_err,
  output logic          o_man_err,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int unsigned BCW = $clog2(DW + 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic [BCW-1:0]  bc_q, bc_d;
  logic            par_q, par_d;
  logic            cmd_q, cmd_d;

  logic            comp;
  logic [DW-1:0]   c_data;
  logic            c_par;
  logic            c_man;
  logic            tmo;

  logic            vld_q, vld_d;
  logic [DW-1:0]   data_q, data_d;
  logic            is_cmd_q, is_cmd_d;
  logic            perr_q, perr_d;
  logic            merr_q, merr_d;
  logic            ovf_q, ovf_d;
  logic            load;
  logic            drop;

`ifdef M1553_WORD_TMO_EN
  m1553_bit_tmo #(
    .TMO_CYC (TMO_CYC),
    .CW      (CW)
  ) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .run_i (state_q != ST_IDLE),
    .clr_i (bit_vld | sync_vld),
    .tmo_o (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  // Next-state and completion decode; priority sync > bit_err > bit_vld > timeout.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bc_d    = bc_q;
    par_d   = par_q;
    cmd_d   = cmd_q;
    comp    = 1'b0;
    c_data  = sh_q;
    c_par   = 1'b0;
    c_man   = 1'b0;
    if (sync_vld) begin
      state_d = ST_SHIFT;
      cmd_d   = sync_cmd;
      sh_d    = '0;
      bc_d    = '0;
      par_d   = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (bit_err) begin
        comp    = 1'b1;
        c_man   = 1'b1;
        state_d = ST_IDLE;
      end else if (bit_vld) begin
        if (state_q == ST_SHIFT) begin
          sh_d  = {sh_q[DW-2:0], bit_val};
          par_d = par_q ^ bit_val;
          bc_d  = bc_q + 1'b1;
          if (bc_q == BCW'(DW - 1)) begin
            state_d = ST_PARITY;
          end
        end else begin
          comp    = 1'b1;
          c_par   = ~(par_q ^ bit_val);
          state_d = ST_IDLE;
        end
      end else if (tmo) begin
        comp    = 1'b1;
        c_man   = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  // FSM and collection registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      bc_q    <= '0;
      par_q   <= 1'b0;
      cmd_q   <= SYNC_DAT;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bc_q    <= bc_d;
      par_q   <= par_d;
      cmd_q   <= cmd_d;
    end
  end

  assign load = comp & (~vld_q | o_rdy);
  assign drop = comp & vld_q & ~o_rdy;

  // Output holding register: load on free slot or same-cycle handshake, else drop.
  always_comb begin
    vld_d    = vld_q;
    data_d   = data_q;
    is_cmd_d = is_cmd_q;
    perr_d   = perr_q;
    merr_d   = merr_q;
    if (load) begin
      vld_d    = 1'b1;
      data_d   = c_data;
      is_cmd_d = (cmd_q == SYNC_CMD);
      perr_d   = c_par;
      merr_d   = c_man;
    end else if (vld_q && o_rdy) begin
      vld_d = 1'b0;
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= 1'b0;
      data_q   <= '0;
      is_cmd_q <= 1'b0;
      perr_q   <= 1'b0;
      merr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      data_q   <= data_d;
      is_cmd_q <= is_cmd_d;
      perr_q   <= perr_d;
      merr_q   <= merr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_vld     = vld_q;
  assign o_data    = data_q;
  assign o_is_cmd  = is_cmd_q;
  assign o_par_err = perr_q;
  assign o_man_err = merr_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_m1553_word_deser.sv
// Self-checking bench for m1553_word_deser: word-level reference model feeds
// a scoreboard queue, a negedge monitor compares whatever the DUT presents.
module tb_m1553_word_deser;

  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          cmd;
    logic          par;
    logic          man;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sync_vld = 1'b0;
  logic          sync_cmd = 1'b0;
  logic          bit_vld = 1'b0;
  logic          bit_val = 1'b0;
  logic          bit_err = 1'b0;
  logic          o_rdy = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          o_vld;
  logic [DW-1:0] o_data;
  logic          o_is_cmd;
  logic          o_par_err;
  logic          o_man_err;
  logic          ovf;

  m1553_word_deser dut (
    .clk       (clk),
    .rst       (rst),
    .sync_vld  (sync_vld),
    .sync_cmd  (sync_cmd),
    .bit_vld   (bit_vld),
    .bit_val   (bit_val),
    .bit_err   (bit_err),
    .o_vld     (o_vld),
    .o_rdy     (o_rdy),
    .o_data    (o_data),
    .o_is_cmd  (o_is_cmd),
    .o_par_err (o_par_err),
    .o_man_err (o_man_err),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Reference model state (word level).
  word_t       sb_q[$];
  bit          m_full = 1'b0;
  bit          m_ovf  = 1'b0;
  bit          m_drop;
  bit          exp_comp = 1'b0;
  word_t       exp_word;
  bit          rnd_rdy = 1'b0;
  bit          m_act = 1'b0;
  int unsigned m_n = 0;
  int unsigned m_val = 0;
  logic        m_cmd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One-deep output buffer model: a completed word loads if the slot is free
  // or is being handed off this cycle, otherwise it is dropped and ovf set.
  always @(posedge clk) begin
    if (!rst) begin
      m_drop = exp_comp && m_full && !o_rdy;
      if (exp_comp) begin
        if (!m_drop) begin
          sb_q.push_back(exp_word);
          m_full = 1'b1;
        end
      end else if (m_full && o_rdy) begin
        m_full = 1'b0;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  // Monitor: compare presented word against scoreboard head, pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("o_vld", 32'(o_vld), 32'(m_full));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (o_vld) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL word: o_vld=1 but no word expected at %0t", $time);
        end else begin
          chk("o_data", 32'(o_data), 32'(sb_q[0].data));
          chk("o_is_cmd", 32'(o_is_cmd), 32'(sb_q[0].cmd));
          chk("o_par_err", 32'(o_par_err), 32'(sb_q[0].par));
          chk("o_man_err", 32'(o_man_err), 32'(sb_q[0].man));
          if (o_rdy) void'(sb_q.pop_front());
        end
      end
    end
  end

  // Random downstream readiness during the random phase.
  always @(posedge clk) begin
    #2;
    if (rnd_rdy) o_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    sync_vld = 1'b0;
    bit_vld  = 1'b0;
    bit_err  = 1'b0;
    bit_val  = 1'b0;
    ovf_clr  = 1'b0;
    exp_comp = 1'b0;
  endtask

  task automatic do_sync(input logic cmd, input logic bv, input logic be);
    sync_vld = 1'b1;
    sync_cmd = cmd;
    bit_vld  = bv;
    bit_err  = be;
    bit_val  = 1'($urandom);
    m_act = 1'b1;
    m_n   = 0;
    m_val = 0;
    m_cmd = cmd;
    cyc();
  endtask

  task automatic do_bit(input logic v, input int unsigned gap);
    int unsigned ones;
    bit_vld = 1'b1;
    bit_val = v;
    if (m_act) begin
      if (m_n == DW) begin
        ones = $countones(m_val) + int'(v);
        exp_word.data = m_val[DW-1:0];
        exp_word.cmd  = m_cmd;
        exp_word.par  = ((ones % 2) == 0);
        exp_word.man  = 1'b0;
        exp_comp = 1'b1;
        m_act = 1'b0;
      end else begin
        m_val = m_val * 2 + int'(v);
        m_n++;
      end
    end
    cyc();
    repeat (gap) cyc();
  endtask

  task automatic do_err(input logic bv, input int unsigned gap);
    bit_err = 1'b1;
    bit_vld = bv;
    bit_val = 1'($urandom);
    if (m_act) begin
      exp_word.data = m_val[DW-1:0];
      exp_word.cmd  = m_cmd;
      exp_word.par  = 1'b0;
      exp_word.man  = 1'b1;
      exp_comp = 1'b1;
      m_act = 1'b0;
    end
    cyc();
    repeat (gap) cyc();
  endtask

  task automatic shift_bits(input logic [DW-1:0] d, input logic p, input int unsigned gap);
    for (int i = 0; i < int'(DW); i++) do_bit(d[DW-1-i], gap);
    do_bit(p, gap);
  endtask

  task automatic send_word(input logic cmd, input logic [DW-1:0] d, input logic p,
                           input int unsigned gap);
    do_sync(cmd, 1'b0, 1'b0);
    shift_bits(d, p, gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_o_vld", 32'(o_vld), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_is_cmd", 32'(o_is_cmd), 32'd0);
    chk("rst_o_par_err", 32'(o_par_err), 32'd0);
    chk("rst_o_man_err", 32'(o_man_err), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    sb_q.delete();
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_act  = 1'b0;
    exp_comp = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          b;
    int unsigned   r;

    do_reset();

    // Strobes in IDLE are ignored.
    do_bit(1'b1, 0);
    do_bit(1'b0, 0);
    do_err(1'b1, 1);

    // Clean and parity-error words.
    o_rdy = 1'b1;
    send_word(1'b1, 16'hA5C3, 1'b1, 0);
    repeat (2) cyc();
    send_word(1'b1, 16'hA5C3, 1'b0, 1);
    send_word(1'b0, 16'h0001, 1'b1, 0);
    send_word(1'b0, 16'h0001, 1'b0, 2);
    repeat (2) cyc();

    // Backpressure: second word dropped, ovf set, then handshake and clear.
    o_rdy = 1'b0;
    send_word(1'b0, 16'h1111, 1'b1, 0);
    send_word(1'b0, 16'h2222, 1'b1, 0);
    repeat (3) cyc();
    o_rdy = 1'b1;
    cyc();
    o_rdy = 1'b0;
    repeat (2) cyc();
    ovf_clr = 1'b1;
    cyc();
    cyc();

    // Back-to-back: completion coincides with handshake of the held word.
    send_word(1'b0, 16'h1111, 1'b1, 0);
    cyc();
    d = 16'h3333;
    do_sync(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(DW); i++) do_bit(d[DW-1-i], 0);
    o_rdy = 1'b1;
    do_bit(1'b1, 0);
    repeat (3) cyc();

    // Manchester abort after 1,0,1,1,0 -> 0x0016.
    do_sync(1'b1, 1'b0, 1'b0);
    do_bit(1'b1, 0); do_bit(1'b0, 0); do_bit(1'b1, 0); do_bit(1'b1, 0); do_bit(1'b0, 0);
    do_err(1'b0, 2);
    // bit_err beats a same-cycle bit_vld.
    do_sync(1'b0, 1'b0, 1'b0);
    do_bit(1'b1, 0); do_bit(1'b1, 0); do_bit(1'b0, 0);
    do_err(1'b1, 2);

    // Sync restart after 8 bits: only the following clean word emits.
    do_sync(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) do_bit(1'b1, 0);
    send_word(1'b1, 16'h00FF, 1'b1, 0);
    cyc();
    // Sync beats same-cycle bit_vld and bit_err.
    do_sync(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_bit(1'b0, 0);
    do_sync(1'b1, 1'b1, 1'b1);
    shift_bits(16'hBEEF, 1'b0, 0);
    repeat (2) cyc();

    // Reset mid-word, then recovery.
    do_sync(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) do_bit(1'($urandom), 0);
    do_reset();
    o_rdy = 1'b1;
    do_bit(1'b1, 0);
    send_word(1'b0, 16'h8001, 1'b1, 0);
    repeat (2) cyc();

`ifdef M1553_WORD_TMO_EN
    // Timeout: bits stop after 3; abort completes 65 cycles after the last bit.
    do_sync(1'b0, 1'b0, 1'b0);
    do_bit(1'b1, 0); do_bit(1'b0, 0); do_bit(1'b1, 0);
    repeat (64) cyc();
    exp_word.data = m_val[DW-1:0];
    exp_word.cmd  = m_cmd;
    exp_word.par  = 1'b0;
    exp_word.man  = 1'b1;
    exp_comp = 1'b1;
    m_act = 1'b0;
    cyc();
    repeat (3) cyc();
`endif

    // Random phase.
    rnd_rdy = 1'b1;
    for (int w = 0; w < 300; w++) begin
      d = 16'($urandom);
      ovf_clr = ($urandom_range(0, 9) == 0);
      do_sync(1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      for (int i = 0; i <= int'(DW); i++) begin
        b = (i < int'(DW)) ? d[DW-1-i] : 1'($urandom);
        r = $urandom_range(0, 99);
        if (r < 2) begin
          do_err(1'($urandom), $urandom_range(0, 3));
          break;
        end else if (r < 4) begin
          break;
        end
        do_bit(b, $urandom_range(0, 3));
      end
      repeat ($urandom_range(0, 3)) cyc();
    end

    // Drain.
    rnd_rdy = 1'b0;
    if (m_act) do_err(1'b0, 0);
    cyc();
    o_rdy = 1'b1;
    for (int k = 0; k < 20 && o_vld; k++) cyc();
    cyc();
    chk("drain_o_vld", 32'(o_vld), 32'd0);
    chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
